leaf_user_in_fifo: RTL and testbench

- Elastic buffer between one leaf interface output port and one user-kernel input port, in the `clk_user` domain.
- Absorbs the leaf interface's vld/ack stream (`dout_leaf_interface2user_N`, `vld_interface2user_N`, `ack_user2interface_N`) and re-presents it to the kernel with a registered, first-word-fall-through output.
- Reports occupancy and almost-full, so kernels with bursty consumption do not stall the leaf interface's BRAM drain.
- One instance per used input port, instantiated inside the user kernel wrapper.

---
 rtl/leaf_user_in_fifo.sv | 118 +++++++++++
 tb/tb_leaf_user_in_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_user_in_fifo.sv
// Elastic FIFO from a leaf interface output port to a user-kernel input port, with a
// registered first-word-fall-through head. Optional word counter: LEAF_USER_FIFO_WORD_CNT_EN.
module leaf_user_in_fifo #(
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_LEVEL  = 12,
  parameter int unsigned CNT_BITS     = $clog2(DEPTH + 1)
) (
  input  logic                    clk_user,
  input  logic                    reset_n,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    vld_in,
  output logic                    ack_out,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    vld_out,
  input  logic                    ack_in,
  output logic [CNT_BITS-1:0]     count,
  output logic                    almost_full
`ifdef LEAF_USER_FIFO_WORD_CNT_EN
  ,
  output logic [31:0]             word_cnt,
  input  logic                    word_cnt_clr
`endif
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam logic [CNT_BITS-1:0] LP_FULL  = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0] LP_AFULL = CNT_BITS'(AFULL_LEVEL);
  localparam logic [CNT_BITS-1:0] LP_TWO   = CNT_BITS'(2);

  logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];
  logic [PTR_BITS-1:0]     r_wr_ptr;
  logic [PTR_BITS-1:0]     r_rd_ptr;
  logic [CNT_BITS-1:0]     r_count;
  logic                    r_ack;
  logic                    r_vld;
  logic [PAYLOAD_BITS-1:0] r_dout;
  logic                    r_afull;

  logic                    w_wr;
  logic                    w_rd;
  logic [CNT_BITS-1:0]     w_count_nxt;
  logic [PTR_BITS-1:0]     w_rd_ptr_nxt;

  always_comb begin
    w_wr         = vld_in & r_ack;
    w_rd         = r_vld & ack_in;
    w_count_nxt  = r_count + CNT_BITS'(w_wr) - CNT_BITS'(w_rd);
    w_rd_ptr_nxt = r_rd_ptr + PTR_BITS'(1);
  end

  // Storage array carries no reset; only pointers and flags are cleared.
  always_ff @(posedge clk_user) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ack    <= 1'b0;
      r_afull  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      r_count <= w_count_nxt;
      // Registered from next count: no combinational path from ack_in to ack_out.
      r_ack   <= (w_count_nxt != LP_FULL);
      r_afull <= (w_count_nxt >= LP_AFULL);
    end
  end

  // Head register mirrors r_mem[r_rd_ptr] once that entry was written on an earlier edge.
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      r_vld  <= 1'b0;
      r_dout <= '0;
    end else if (w_rd) begin
      r_vld <= (r_count >= LP_TWO);
      if (r_count >= LP_TWO) begin
        r_dout <= r_mem[w_rd_ptr_nxt];
      end
    end else if (!r_vld && (r_count != '0)) begin
      r_vld  <= 1'b1;
      r_dout <= r_mem[r_rd_ptr];
    end
  end

`ifdef LEAF_USER_FIFO_WORD_CNT_EN
  logic [31:0] r_word_cnt;

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      r_word_cnt <= '0;
    end else if (word_cnt_clr) begin
      r_word_cnt <= '0;
    end else if (w_rd) begin
      r_word_cnt <= r_word_cnt + 32'd1;
    end
  end

  assign word_cnt = r_word_cnt;
`endif

  assign ack_out     = r_ack;
  assign dout        = r_dout;
  assign vld_out     = r_vld;
  assign count       = r_count;
  assign almost_full = r_afull;

endmodule

// File: tb/tb_leaf_user_in_fifo.sv
// Directed + randomized bench for leaf_user_in_fifo, checked against a queue-based model.
module tb_leaf_user_in_fifo;

  logic        clk_user = 1'b0;
  logic        reset_n;
  logic [31:0] din;
  logic        vld_in;
  logic        ack_out;
  logic [31:0] dout;
  logic        vld_out;
  logic        ack_in;
  logic [4:0]  count;
  logic        almost_full;
`ifdef LEAF_USER_FIFO_WORD_CNT_EN
  logic [31:0] word_cnt;
  logic        word_cnt_clr;
  int unsigned wc;
`endif

  always #5 clk_user = ~clk_user;

  leaf_user_in_fifo dut (
    .clk_user    (clk_user),
    .reset_n     (reset_n),
    .din         (din),
    .vld_in      (vld_in),
    .ack_out     (ack_out),
    .dout        (dout),
    .vld_out     (vld_out),
    .ack_in      (ack_in),
    .count       (count),
    .almost_full (almost_full)
`ifdef LEAF_USER_FIFO_WORD_CNT_EN
    ,
    .word_cnt    (word_cnt),
    .word_cnt_clr(word_cnt_clr)
`endif
  );

  // Model: every stored word with the edge number at which it was accepted.
  typedef struct {
    logic [31:0] d;
    int          st;
  } ent_t;

  ent_t q[$];
  int   ec;
  bit   exp_ack;
  bit   exp_vld;
  int   n_vec;
  int   n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_ack = 1'b0;
    exp_vld = 1'b0;
`ifdef LEAF_USER_FIFO_WORD_CNT_EN
    wc = 0;
`endif
  endtask

  // Check outputs against the model, advance one clock, update the model.
  task automatic step(output bit wr, output bit rd);
    logic [31:0] d;
    chk("vld_out", 32'(vld_out), 32'(exp_vld));
    chk("count", 32'(count), 32'(q.size()));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= 12));
    chk("ack_out", 32'(ack_out), 32'(exp_ack));
    if (exp_vld) chk("dout", dout, q[0].d);
`ifdef LEAF_USER_FIFO_WORD_CNT_EN
    chk("word_cnt", word_cnt, wc);
`endif
    wr = vld_in && exp_ack;
    rd = ack_in && exp_vld;
    d  = din;
    @(posedge clk_user);
    #1;
    ec++;
`ifdef LEAF_USER_FIFO_WORD_CNT_EN
    if (word_cnt_clr) wc = 0;
    else if (rd) wc++;
`endif
    if (rd) void'(q.pop_front());
    if (wr) q.push_back('{d: d, st: ec});
    exp_ack = (q.size() != 16);
    // Head is visible only if it was stored before the edge just taken.
    exp_vld = (q.size() > 0) && (q[0].st < ec);
  endtask

  task automatic drain();
    bit wr, rd;
    vld_in = 1'b0;
    ack_in = 1'b1;
    for (int i = 0; i < 40 && (q.size() > 0 || exp_vld); i++) step(wr, rd);
    ack_in = 1'b0;
    step(wr, rd);
    chk("drained_count", 32'(count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wr, rd;
    int nxt, rx;
    n_vec   = 0;
    n_err   = 0;
    ec      = 0;
    reset_n = 1'b0;
    din     = '0;
    vld_in  = 1'b0;
    ack_in  = 1'b0;
`ifdef LEAF_USER_FIFO_WORD_CNT_EN
    word_cnt_clr = 1'b0;
`endif
    model_reset();
    #1;
    chk("rst_vld", 32'(vld_out), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_dout", dout, 32'd0);
    @(posedge clk_user);
    #1;
    reset_n = 1'b1;
    step(wr, rd);
    chk("ack_after_reset", 32'(ack_out), 32'd1);

    // Single word
    din    = 32'hDEADBEEF;
    vld_in = 1'b1;
    step(wr, rd);
    vld_in = 1'b0;
    step(wr, rd);
    chk("single_vld", 32'(vld_out), 32'd1);
    chk("single_dout", dout, 32'hDEADBEEF);
    chk("single_count", 32'(count), 32'd1);
    ack_in = 1'b1;
    step(wr, rd);
    ack_in = 1'b0;
    chk("single_vld_after", 32'(vld_out), 32'd0);
    chk("single_count_after", 32'(count), 32'd0);
    step(wr, rd);

    // Fill to full, then hold a 17th word
    vld_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = 32'(i);
      step(wr, rd);
    end
    din = 32'd16;
    chk("full_count", 32'(count), 32'd16);
    chk("full_ack", 32'(ack_out), 32'd0);
    chk("full_afull", 32'(almost_full), 32'd1);
    for (int i = 0; i < 3; i++) step(wr, rd);
    chk("held_count", 32'(count), 32'd16);

    // Full with simultaneous read: refused now, accepted next cycle
    ack_in = 1'b1;
    step(wr, rd);
    ack_in = 1'b0;
    chk("fullrd_count", 32'(count), 32'd15);
    chk("fullrd_ack", 32'(ack_out), 32'd1);
    step(wr, rd);
    chk("held_accepted_count", 32'(count), 32'd16);
    drain();

    // Reset mid-burst with 5 words queued
    vld_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 32'h100 + 32'(i);
      step(wr, rd);
    end
    vld_in = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_vld", 32'(vld_out), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_afull", 32'(almost_full), 32'd0);
    model_reset();
    @(posedge clk_user);
    #1;
    reset_n = 1'b1;
    ack_in  = 1'b1;
    for (int i = 0; i < 6; i++) step(wr, rd);
    ack_in = 1'b0;

    // Random stream of 100 incrementing words
    nxt = 0;
    rx  = 0;
    for (int c = 0; c < 3000 && rx < 100; c++) begin
      if (!vld_in && nxt < 100 && $urandom_range(0, 3) != 0) begin
        vld_in = 1'b1;
        din    = 32'(nxt);
      end
      ack_in = 1'($urandom_range(0, 1));
      if (ack_in && exp_vld) begin
        chk("order", dout, 32'(rx));
        rx++;
      end
      step(wr, rd);
      if (wr) begin
        nxt++;
        vld_in = 1'b0;
      end
    end
    chk("rx_total", 32'(rx), 32'd100);
    drain();

`ifdef LEAF_USER_FIFO_WORD_CNT_EN
    word_cnt_clr = 1'b1;
    step(wr, rd);
    word_cnt_clr = 1'b0;
    vld_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 32'h200 + 32'(i);
      step(wr, rd);
    end
    vld_in = 1'b0;
    ack_in = 1'b1;
    for (int i = 0; i < 7; i++) step(wr, rd);
    chk("wc_seven", word_cnt, 32'd7);
    word_cnt_clr = 1'b1;
    step(wr, rd);
    word_cnt_clr = 1'b0;
    chk("wc_cleared", word_cnt, 32'd0);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
